// File: rtl/mem_burst_master.sv
// Burst initiator for the single-port word memory (cs = read, we = write, 1-cycle read latency).
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned requests with an err pulse.
module mem_burst_master #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [WIDTH-1:0] req_addr_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             rsp_valid_o,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_last_o,
    output logic             done_o,
    output logic             err_o,
    output logic             mem_cs_o,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic [WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_DRAIN,
        WR,
        WR_FLUSH
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] cur_addr_q;
    logic [WIDTH-1:0] cur_addr_d;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    logic             mem_cs_q;
    logic             mem_we_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;
    logic             rsp_valid_q;
    logic             rsp_last_q;
    logic             done_q;
`ifdef MEM_ALIGN_CHECK_EN
    logic             err_q;
`endif

    assign cur_addr_d = cur_addr_q + WIDTH'(4);
    assign cnt_d      = cnt_q - LEN_W'(1);

    // Read data bypasses the master: the memory output is already registered.
    assign req_ready_o = (state_q == IDLE);
    assign wr_ready_o  = (state_q == WR);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = mem_rdata_i;
    assign rsp_last_o  = rsp_last_q;
    assign done_o      = done_q;
    assign mem_cs_o    = mem_cs_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            cnt_q       <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            // A read beat returns exactly one cycle after its select cycle.
            rsp_valid_q <= mem_cs_q;
            rsp_last_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            err_q       <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        cnt_q <= req_len_i;
`ifdef MEM_ALIGN_CHECK_EN
                        if (req_addr_i[1:0] != 2'b00) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= RD_DRAIN;
                        end else
`endif
                        if (req_we_i) begin
                            cur_addr_q <= req_addr_i;
                            state_q    <= WR;
                        end else begin
                            mem_cs_q   <= 1'b1;
                            mem_addr_q <= req_addr_i;
                            cur_addr_q <= req_addr_i + WIDTH'(4);
                            state_q    <= RD;
                        end
                    end
                end
                RD: begin
                    if (cnt_q == '0) begin
                        mem_cs_q   <= 1'b0;
                        rsp_last_q <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= RD_DRAIN;
                    end else begin
                        mem_addr_q <= cur_addr_q;
                        cur_addr_q <= cur_addr_d;
                        cnt_q      <= cnt_d;
                    end
                end
                RD_DRAIN: begin
                    state_q <= IDLE;
                end
                WR: begin
                    if (wr_valid_i) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cur_addr_q;
                        mem_wdata_q <= wr_data_i;
                        cur_addr_q  <= cur_addr_d;
                        cnt_q       <= cnt_d;
                        // done rides along with the flush cycle that commits the final word.
                        if (cnt_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= WR_FLUSH;
                        end
                    end else begin
                        mem_we_q <= 1'b0;
                    end
                end
                WR_FLUSH: begin
                    mem_we_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Self-checking bench for mem_burst_master: request table plus scoreboard of memory writes and read beats.
// Honours MEM_ALIGN_CHECK_EN in the same way as the design.
module tb_mem_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [2:0]  req_len_i;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [31:0] wr_data_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_last_o;
    logic        done_o;
    logic        err_o;
    logic        mem_cs_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'h0;

    mem_burst_master #(.WIDTH(32), .LEN_W(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_last_o(rsp_last_o),
        .done_o(done_o), .err_o(err_o),
        .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [2:0]  len;
        bit          gap;
        logic [31:0] base;
        int          expLat;
        bit          expErr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    typedef struct {
        logic [31:0] data;
        bit          last;
        int          cyc;
    } rd_exp_t;

    wr_exp_t  wrQ[$];
    rd_exp_t  rdQ[$];
    bit [31:0] mem[256];
    bit [31:0] sh[256];
    vec_t     vecs[11];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    int       doneCount = 0;
    int       doneCyc = 0;
    bit       doneErr = 1'b0;

    // Word memory with a registered read port; low address bits are ignored.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we_o) mem[mem_addr_o[9:2]] <= mem_wdata_o;
        if (mem_cs_o) mem_rdata_i <= mem[mem_addr_o[9:2]];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops scoreboard entries as the DUT writes memory or returns read beats.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_cs_o && mem_we_o) checkOutput("cs_we_exclusive", 32'h1, 32'h0);
            if (mem_we_o) begin
                if (wrQ.size() == 0) begin
                    checkOutput("unexpected_write", mem_addr_o, 32'hFFFF_FFFF);
                end else begin
                    wr_exp_t e;
                    e = wrQ.pop_front();
                    checkOutput("wr_addr", mem_addr_o, e.addr);
                    checkOutput("wr_data", mem_wdata_o, e.data);
                end
            end
            if (rsp_valid_o) begin
                if (rdQ.size() == 0) begin
                    checkOutput("unexpected_rsp", rsp_data_o, 32'hFFFF_FFFF);
                end else begin
                    rd_exp_t r;
                    r = rdQ.pop_front();
                    checkOutput("rsp_data", rsp_data_o, r.data);
                    checkOutput("rsp_last", {31'b0, rsp_last_o}, {31'b0, r.last});
                    checkOutput("rsp_cycle", cyc, r.cyc);
                end
            end
            if (done_o) begin
                doneCount++;
                doneCyc = cyc;
                doneErr = err_o;
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        int acc;
        int startDone;
        logic [31:0] a;
        logic [31:0] d;
        @(posedge clk); #1;
        req_valid_i = 1'b1;
        req_we_i    = v.we;
        req_addr_i  = v.addr;
        req_len_i   = v.len;
        @(negedge clk);
        checkOutput("req_ready_idle", {31'b0, req_ready_o}, 32'h1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        acc = cyc;
        startDone = doneCount;
        if (!v.expErr) begin
            for (int i = 0; i <= int'(v.len); i++) begin
                a = v.addr + 32'(4 * i);
                if (v.we) begin
                    if (v.gap) begin
                        wr_valid_i = 1'b0;
                        @(posedge clk); #1;
                    end
                    d = v.base + 32'(i);
                    checkOutput("wr_ready", {31'b0, wr_ready_o}, 32'h1);
                    wr_valid_i = 1'b1;
                    wr_data_i  = d;
                    wrQ.push_back('{a, d});
                    sh[a[9:2]] = d;
                    @(posedge clk); #1;
                    wr_valid_i = 1'b0;
                end else begin
                    rdQ.push_back('{sh[a[9:2]], (i == int'(v.len)), acc + 1 + i});
                end
            end
        end
        for (int k = 0; k < 40 && doneCount == startDone; k++) @(negedge clk);
        if (doneCount == startDone) begin
            checkOutput("done_timeout", 32'h0, 32'h1);
        end else begin
            checkOutput("done_latency", doneCyc - acc + 1, v.expLat);
            checkOutput("done_err", {31'b0, doneErr}, {31'b0, v.expErr});
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_mem_cs"}, {31'b0, mem_cs_o}, 32'h0);
        checkOutput({tag, "_mem_we"}, {31'b0, mem_we_o}, 32'h0);
        checkOutput({tag, "_mem_addr"}, mem_addr_o, 32'h0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
        checkOutput({tag, "_rsp_valid"}, {31'b0, rsp_valid_o}, 32'h0);
        checkOutput({tag, "_rsp_last"}, {31'b0, rsp_last_o}, 32'h0);
        checkOutput({tag, "_done"}, {31'b0, done_o}, 32'h0);
        checkOutput({tag, "_err"}, {31'b0, err_o}, 32'h0);
        checkOutput({tag, "_req_ready"}, {31'b0, req_ready_o}, 32'h1);
        checkOutput({tag, "_wr_ready"}, {31'b0, wr_ready_o}, 32'h0);
    endtask

    initial begin
        vec_t tail;
        int   savedDone;
        //        we    addr            len   gap   base            lat err
        vecs[0]  = '{1'b1, 32'h0000_0010, 3'd0, 1'b0, 32'hDEAD_BEEF, 2, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 3'd0, 1'b0, 32'h0,         2, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0020, 3'd3, 1'b0, 32'h1,         5, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0020, 3'd3, 1'b0, 32'h0,         5, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0040, 3'd2, 1'b1, 32'hA0,        7, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0040, 3'd2, 1'b0, 32'h0,         4, 1'b0};
        vecs[6]  = '{1'b1, 32'hFFFF_FFFC, 3'd1, 1'b0, 32'h55,        3, 1'b0};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFC, 3'd1, 1'b0, 32'h0,         3, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0080, 3'd7, 1'b0, 32'h100,       9, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0080, 3'd7, 1'b0, 32'h0,         9, 1'b0};
`ifdef MEM_ALIGN_CHECK_EN
        vecs[10] = '{1'b0, 32'h0000_0013, 3'd0, 1'b0, 32'h0,         1, 1'b1};
`else
        vecs[10] = '{1'b0, 32'h0000_0013, 3'd0, 1'b0, 32'h0,         2, 1'b0};
`endif

        rst = 1'b1;
        req_valid_i = 1'b0;
        req_we_i = 1'b0;
        req_addr_i = 32'h0;
        req_len_i = 3'd0;
        wr_valid_i = 1'b0;
        wr_data_i = 32'h0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int n = 0; n < 11; n++) applyStimulus(vecs[n]);

        // Reset lands after the first of four write beats has been committed.
        @(posedge clk); #1;
        req_valid_i = 1'b1;
        req_we_i = 1'b1;
        req_addr_i = 32'h60;
        req_len_i = 3'd3;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        savedDone = doneCount;
        wr_valid_i = 1'b1;
        wr_data_i = 32'h77;
        wrQ.push_back('{32'h60, 32'h77});
        sh[8'h18] = 32'h77;
        @(posedge clk); #1;
        wr_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        wr_valid_i = 1'b1;
        wr_data_i = 32'h99;
        @(negedge clk);
        checkResetOutputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wr_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midreset_beat1", mem[8'h18], 32'h77);
        checkOutput("midreset_beat2", mem[8'h19], 32'h0);
        checkOutput("midreset_no_done", doneCount, savedDone);

        tail = '{1'b0, 32'h0000_0060, 3'd1, 1'b0, 32'h0, 3, 1'b0};
        applyStimulus(tail);

        repeat (3) @(negedge clk);
        checkOutput("wrQ_empty", wrQ.size(), 32'h0);
        checkOutput("rdQ_empty", rdQ.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
